// File: rtl/matmul_host_sequencer.sv
// matmul_host_sequencer: streams A/B words into the matmul BRAMs, runs the
// multiply, then reads C back onto a valid/ready stream through a skid FIFO.
// Ports: cmd_valid/cmd_ready start a job; in_valid/in_ready/in_data carry
// A then B words; out_valid/out_ready/out_data/out_last return C words;
// enable_*, addr_pi, data_pi, we_*, start_mat_mul, done_mat_mul and
// data_from_out_mat form the matmul host port; busy is state != IDLE.
// Optional macro MATMUL_SEQ_TIMEOUT_EN adds a COMPUTE watchdog driving err.
module matmul_host_sequencer #(
  parameter int DWIDTH         = 8,
  parameter int BB_SIZE        = 4,
  parameter int AWIDTH         = 7,
  parameter int NUM_WORDS      = 8,
  parameter int RD_LAT         = 4,
  parameter int OFIFO_DEPTH    = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BB_SIZE*DWIDTH-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BB_SIZE*DWIDTH-1:0] out_data,
  output logic                      out_last,
  output logic                      enable_writing_to_mem,
  output logic                      enable_reading_from_mem,
  output logic [AWIDTH-1:0]         addr_pi,
  output logic [BB_SIZE*DWIDTH-1:0] data_pi,
  output logic                      we_a,
  output logic                      we_b,
  output logic                      we_c,
  output logic                      start_mat_mul,
  input  logic                      done_mat_mul,
  input  logic [BB_SIZE*DWIDTH-1:0] data_from_out_mat,
  output logic                      busy,
  output logic                      err
);
  localparam int W  = BB_SIZE * DWIDTH;
  localparam int CW = $clog2(NUM_WORDS + 1);
  localparam int FW = $clog2(OFIFO_DEPTH + 1);
  localparam int PW = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int QW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

  if (OFIFO_DEPTH < RD_LAT + 1 || RD_LAT < 1 ||
      TIMEOUT_CYCLES < 1 || NUM_WORDS > (1 << AWIDTH)) begin : g_cfg_bad
    $error("matmul_host_sequencer: inconsistent parameters");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_GAP,
    S_COMPUTE, S_READ, S_FLUSH
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [FW-1:0]   outstanding, fcnt;
  logic [FW:0]     occ;
  logic [RD_LAT-1:0] vld;
  logic [PW-1:0]   wp, rp;
  logic [QW-1:0]   pcnt;
  logic [W-1:0]    mem [OFIFO_DEPTH];
  logic            issue, push, pop, tmo_hit;

  assign push      = vld[RD_LAT-1];
  assign out_valid = (fcnt != '0);
  assign pop       = out_valid && out_ready;
  assign out_data  = mem[rp];
  assign out_last  = out_valid && (pcnt == QW'(NUM_WORDS - 1));
  assign busy      = (state != S_IDLE);
  // Occupancy counts reads still in the pipe so the FIFO cannot overflow.
  assign occ       = (FW+1)'(outstanding) + (FW+1)'(fcnt);

  always_comb begin
    state_n                 = state;
    cnt_n                   = cnt;
    cmd_ready               = 1'b0;
    in_ready                = 1'b0;
    enable_writing_to_mem   = 1'b0;
    enable_reading_from_mem = 1'b0;
    addr_pi                 = '0;
    data_pi                 = '0;
    we_a                    = 1'b0;
    we_b                    = 1'b0;
    we_c                    = 1'b0;
    start_mat_mul           = 1'b0;
    issue                   = 1'b0;
    unique case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // Matmul registers the enable, so raise it a cycle early.
          enable_writing_to_mem = 1'b1;
          cnt_n   = '0;
          state_n = S_LOAD_A;
        end
      end
      S_LOAD_A, S_LOAD_B: begin
        in_ready              = 1'b1;
        enable_writing_to_mem = 1'b1;
        if (in_valid) begin
          addr_pi = AWIDTH'(cnt);
          data_pi = in_data;
          we_a    = (state == S_LOAD_A);
          we_b    = (state == S_LOAD_B);
          if (cnt == CW'(NUM_WORDS - 1)) begin
            cnt_n   = '0;
            state_n = (state == S_LOAD_A) ? S_LOAD_B : S_GAP;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_GAP: state_n = S_COMPUTE;
      S_COMPUTE: begin
        if (done_mat_mul) begin
          enable_reading_from_mem = 1'b1;
          cnt_n   = '0;
          state_n = S_READ;
        end else if (tmo_hit) begin
          state_n = S_IDLE;
        end else begin
          start_mat_mul = 1'b1;
          we_c          = 1'b1;
        end
      end
      S_READ: begin
        if (cnt == CW'(NUM_WORDS) && outstanding == '0) begin
          state_n = S_FLUSH;
        end else begin
          enable_reading_from_mem = 1'b1;
          if (cnt < CW'(NUM_WORDS) && occ < (FW+1)'(OFIFO_DEPTH)) begin
            issue   = 1'b1;
            addr_pi = AWIDTH'(cnt);
            cnt_n   = cnt + 1'b1;
          end
        end
      end
      S_FLUSH: if (fcnt == '0) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      outstanding <= '0;
      vld         <= '0;
      wp          <= '0;
      rp          <= '0;
      fcnt        <= '0;
      pcnt        <= '0;
      for (int i = 0; i < OFIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      vld         <= (vld << 1) | RD_LAT'(issue);
      outstanding <= outstanding + FW'(issue) - FW'(push);
      fcnt        <= fcnt + FW'(push) - FW'(pop);
      if (push) begin
        mem[wp] <= data_from_out_mat;
        wp <= (wp == PW'(OFIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
      end
      if (pop) begin
        rp <= (rp == PW'(OFIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
        pcnt <= (pcnt == QW'(NUM_WORDS - 1)) ? '0 : pcnt + 1'b1;
      end
    end
  end

`ifdef MATMUL_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tcnt;
  logic          err_q;
  logic          in_cmp;

  assign in_cmp  = (state == S_COMPUTE) && !done_mat_mul;
  assign tmo_hit = (tcnt == TW'(TIMEOUT_CYCLES));
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      tcnt <= in_cmp ? tcnt + 1'b1 : '0;
      if (in_cmp && tmo_hit) err_q <= 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif
endmodule

// File: tb/tb_matmul_host_sequencer.sv
// tb_matmul_host_sequencer: random jobs against a behavioural matmul
// stand-in and a queue model of the expected writes and C stream.
module tb_matmul_host_sequencer;
  localparam int N   = 8;
  localparam int RL  = 4;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        done_mat_mul = 1'b0;
  logic [31:0] in_data = '0;
  logic [31:0] data_from_out_mat;
  logic        cmd_ready, in_ready, out_valid, out_last;
  logic        ew, er, we_a, we_b, we_c, start, busy, err;
  logic [6:0]  addr_pi;
  logic [31:0] data_pi, out_data;

  always #5 clk = ~clk;

  matmul_host_sequencer #(
    .DWIDTH(8), .BB_SIZE(4), .AWIDTH(7), .NUM_WORDS(N),
    .RD_LAT(RL), .OFIFO_DEPTH(8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last),
    .enable_writing_to_mem(ew), .enable_reading_from_mem(er),
    .addr_pi(addr_pi), .data_pi(data_pi),
    .we_a(we_a), .we_b(we_b), .we_c(we_c),
    .start_mat_mul(start), .done_mat_mul(done_mat_mul),
    .data_from_out_mat(data_from_out_mat),
    .busy(busy), .err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Stand-in C: per-byte product of A and B words (mod 256).
  function automatic logic [31:0] bytemul(input logic [31:0] a,
                                          input logic [31:0] b);
    logic [31:0] r;
    logic [15:0] p;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      p = 16'(a[8*k +: 8]) * 16'(b[8*k +: 8]);
      r[8*k +: 8] = p[7:0];
    end
    return r;
  endfunction

  // ---- matmul stand-in ----
  logic [31:0]   amem [N];
  logic [31:0]   bmem [N];
  logic [31:0]   cmem [N];
  logic [RL-1:0] rp_v = '0;
  logic [2:0]    rp_a [RL];
  logic [31:0]   junk = '0;
  int            scnt = 0;
  int            done_delay = 0;
  bit            hold_done = 1'b0;
  bit            spur_en = 1'b0;

  assign data_from_out_mat = rp_v[RL-1] ? cmem[rp_a[RL-1]] : junk;

  always @(posedge clk) begin
    junk    <= $urandom;
    rp_v    <= {rp_v[RL-2:0], er};
    rp_a[0] <= addr_pi[2:0];
    for (int k = 1; k < RL; k++) rp_a[k] <= rp_a[k-1];
    if (we_a) amem[addr_pi[2:0]] <= data_pi;
    if (we_b) bmem[addr_pi[2:0]] <= data_pi;
    if (done_mat_mul) begin
      done_mat_mul <= 1'b0;
    end else if (start) begin
      if (!hold_done && scnt >= done_delay) begin
        done_mat_mul <= 1'b1;
        for (int i = 0; i < N; i++) cmem[i] <= bytemul(amem[i], bmem[i]);
        scnt <= 0;
      end else begin
        scnt <= scnt + 1;
      end
    end else begin
      scnt <= 0;
      if (spur_en && in_ready && $urandom_range(0, 3) == 0)
        done_mat_mul <= 1'b1;
    end
  end

  // ---- reference model and compare process ----
  logic [31:0] job_a [N];
  logic [31:0] job_b [N];
  logic [31:0] exp_out [$];
  logic [31:0] first_out, last_out, e;
  int          wa_idx = 0, wb_idx = 0, pops = 0;
  bit          model_on = 1'b0;
  bit          prev_ew = 1'b0, prev_start = 1'b0, want_ew_low = 1'b0;

  always @(negedge clk) begin
    if (!reset && model_on) begin
      chk("cmd_ready_vs_busy", cmd_ready, !busy);
      chk("we_c_eq_start", we_c, start);
      if (we_a) begin
        chk("we_a_in_range", wa_idx < N, 1);
        if (wa_idx < N) begin
          chk("we_a_addr", addr_pi, wa_idx);
          chk("we_a_data", data_pi, job_a[wa_idx]);
          chk("we_a_accepted", in_valid && in_ready, 1);
          if (wa_idx == 0) chk("ew_lead", prev_ew, 1);
        end
        wa_idx++;
      end
      if (want_ew_low) begin
        chk("ew_drop", ew, 0);
        want_ew_low = 1'b0;
      end
      if (we_b) begin
        chk("we_b_after_a", wa_idx, N);
        chk("we_b_in_range", wb_idx < N, 1);
        if (wb_idx < N) begin
          chk("we_b_addr", addr_pi, wb_idx);
          chk("we_b_data", data_pi, job_b[wb_idx]);
          chk("we_b_accepted", in_valid && in_ready, 1);
        end
        wb_idx++;
        if (wb_idx == N) want_ew_low = 1'b1;
      end
      if (we_a || we_b) chk("ew_during_write", ew, 1);
      if (prev_start && done_mat_mul) begin
        chk("start_drop_on_done", start, 0);
        chk("read_en_on_done", er, 1);
      end
      if (out_valid && out_ready) begin
        chk("out_pending", exp_out.size() > 0, 1);
        if (exp_out.size() > 0) begin
          e = exp_out.pop_front();
          chk("out_data", out_data, e);
          chk("out_last", out_last, pops == N - 1);
        end
        if (pops == 0) first_out = out_data;
        last_out = out_data;
        pops++;
      end
`ifndef MATMUL_SEQ_TIMEOUT_EN
      chk("err_low", err, 0);
`endif
    end
    prev_ew    = ew;
    prev_start = start;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cmd_valid = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  // mode 0: no stalls, fixed data; 1: in_valid toggles; 2: random.
  task automatic run_job(input int mode, input bit bp,
                         input bit abort_b3, input bit tmo);
    int idx, guard, tmr, sc;
    bit acc;
    for (int i = 0; i < N; i++) begin
      if (mode == 0) begin
        job_a[i] = 32'h01010101 * (i + 1);
        job_b[i] = 32'h01010101;
      end else begin
        job_a[i] = $urandom;
        job_b[i] = $urandom;
      end
    end
    exp_out.delete();
    if (!tmo)
      for (int i = 0; i < N; i++)
        exp_out.push_back(bytemul(job_a[i], job_b[i]));
    wa_idx = 0;
    wb_idx = 0;
    pops = 0;
    want_ew_low = 1'b0;
    done_delay = $urandom_range(0, 12);
    model_on = 1'b1;

    cmd_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = cmd_ready;
      tick();
      guard++;
    end while (!acc && guard < 50);
    cmd_valid = 1'b0;
    chk("cmd_accepted", acc, 1);

    idx = 0;
    guard = 0;
    while (idx < 2 * N && guard < 500) begin
      if (mode == 0) in_valid = 1'b1;
      else if (mode == 1) in_valid = (guard % 2 == 0);
      else in_valid = ($urandom_range(0, 3) != 0);
      in_data = (idx < N) ? job_a[idx] : job_b[idx - N];
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      guard++;
      if (acc) idx++;
      if (abort_b3 && idx == N + 4) begin
        in_valid = 1'b0;
        reset = 1'b1;
        tick();
        chk("abort_idle", busy, 0);
        chk("abort_we_b", we_b, 0);
        chk("abort_cmd_ready", cmd_ready, 1);
        reset = 1'b0;
        model_on = 1'b0;
        exp_out.delete();
        return;
      end
    end
    in_valid = 1'b0;
    chk("load_done", idx, 2 * N);

    if (tmo) begin
      sc = 0;
      guard = 0;
      while (!start && guard < 20) begin tick(); guard++; end
      while (start && guard < 300) begin sc++; tick(); guard++; end
      chk("tmo_start_cycles", sc, TMO);
      tick();
      chk("tmo_err", err, 1);
      chk("tmo_idle", busy, 0);
      for (int i = 0; i < 10; i++) begin
        chk("tmo_no_out", out_valid, 0);
        chk("tmo_no_read", er, 0);
        tick();
      end
      return;
    end

    guard = 0;
    tmr = 0;
    while ((pops < N || busy) && guard < 3000) begin
      if (bp && tmr < 20) begin
        out_ready = 1'b0;
        if (er || tmr > 0) tmr++;
        if (tmr == 20) begin
          chk("bp_fifo_holds", out_valid, 1);
          chk("bp_no_pop", pops, 0);
          chk("bp_reads_done", er, 0);
          chk("bp_still_busy", busy, 1);
        end
      end else if (mode == 0 || bp) begin
        out_ready = 1'b1;
      end else begin
        out_ready = ($urandom_range(0, 2) != 0);
      end
      tick();
      guard++;
    end
    out_ready = 1'b0;
    chk("drain_done", pops, N);
    chk("outq_empty", exp_out.size(), 0);
    chk("wa_count", wa_idx, N);
    chk("wb_count", wb_idx, N);
    chk("job_cmd_ready", cmd_ready, 1);
    if (mode == 0) begin
      chk("pin_first_out", first_out, 32'h01010101);
      chk("pin_last_out", last_out, 32'h08080808);
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);
      chk("rst_ctrl", {ew, er, we_a, we_b, we_c, start}, 0);
      chk("rst_addr", addr_pi, 0);
      chk("rst_out", {out_valid, out_last}, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err, 0);
    end
    tick();
    run_job(0, 1'b0, 1'b0, 1'b0);
    run_job(1, 1'b0, 1'b0, 1'b0);
    run_job(2, 1'b1, 1'b0, 1'b0);
    run_job(2, 1'b0, 1'b1, 1'b0);
    run_job(2, 1'b0, 1'b0, 1'b0);
    spur_en = 1'b1;
    for (int j = 0; j < 6; j++)
      run_job(2, (j % 3 == 0), 1'b0, 1'b0);
    spur_en = 1'b0;
`ifdef MATMUL_SEQ_TIMEOUT_EN
    hold_done = 1'b1;
    run_job(2, 1'b0, 1'b0, 1'b1);
    hold_done = 1'b0;
    model_on = 1'b0;
    do_reset();
    @(negedge clk);
    chk("err_cleared", err, 0);
    tick();
    run_job(2, 1'b0, 1'b0, 1'b0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end
endmodule
